pkt_stream_src: RTL and testbench

PKT_STREAM_SRC -- requirements
Module: pkt_stream_src

---
 rtl/pe_types.sv | 25 ++
 rtl/pkt_stream_src.sv | 184 ++++++++++++++++++
 tb/tb_pkt_stream_src.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_types.sv
// Shared types for the packet-engine blocks.
//   packet_t       : one buffered packet (tag + payload), 32 bits packed.
//   stream_state_t : stream source FSM states.
//   min1_clog2()   : ceil(log2(n)) but never below 1, for select fields
//                    that must keep at least one bit (e.g. a channel index
//                    when there is only one channel).
package pe_types;

  typedef struct packed {
    logic [7:0]  tag;
    logic [23:0] payload;
  } packet_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } stream_state_t;

  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pkt_stream_src.sv
// Packet stream source.
// Holds a small packet buffer that is loaded while idle, then on start
// streams the first cfg_len entries (in order, from entry 0) to one
// downstream FIFO (unicast) or to all of them at once (broadcast),
// optionally inserting cfg_gap idle cycles after every accepted packet.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   load_en/addr/data       buffer write port (ignored while busy)
//   start                   one-cycle stream request (ignored while busy)
//   cfg_len/gap/bcast/ch    stream configuration, latched on start
//   abort                   kill the active stream, no done pulse
//   out_full[NUM_CH]        downstream FIFO full flags
//   out_enq[NUM_CH]         downstream FIFO enqueue strobes
//   out_wdata[NUM_CH]       downstream FIFO write data (same on every lane)
//   busy                    high in SEND and GAP
//   done                    one-cycle pulse after the last packet
//   sent_cnt                packets accepted by the current/last stream
module pkt_stream_src
  import pe_types::*;
#(
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 64,
  parameter int GAP_W  = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CH_W  = min1_clog2(NUM_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_en,
  input  logic [AW-1:0]          load_addr,
  input  packet_t                load_data,
  input  logic                   start,
  input  logic [AW:0]            cfg_len,
  input  logic [GAP_W-1:0]       cfg_gap,
  input  logic                   cfg_bcast,
  input  logic [CH_W-1:0]        cfg_ch,
  input  logic                   abort,
  input  logic [NUM_CH-1:0]      out_full,
  output logic [NUM_CH-1:0]      out_enq,
  output packet_t [NUM_CH-1:0]   out_wdata,
  output logic                   busy,
  output logic                   done,
  output logic [AW:0]            sent_cnt
);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  stream_state_t     state_reg;
  stream_state_t     state_next;
  logic [AW-1:0]     ptr_reg;
  logic [AW:0]       sent_cnt_reg;
  logic [AW:0]       len_reg;
  logic [GAP_W-1:0]  gap_reg;
  logic [GAP_W-1:0]  gap_cnt_reg;
  logic              bcast_reg;
  logic [CH_W-1:0]   ch_reg;

  // Packet buffer: plain register array, combinational read, not reset.
  packet_t           buf_mem [DEPTH];

  logic [NUM_CH-1:0] target_mask;
  logic              accept;
  logic              last_pkt;

  // ---------------------------------------------------------------------
  // Target set and accept decode
  // ---------------------------------------------------------------------
  // A unicast channel index outside 0..NUM_CH-1 selects no lane, so such a
  // stream drains the buffer without enqueuing anywhere.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_lane
      assign target_mask[gi] = bcast_reg || (ch_reg == CH_W'(gi));
      assign out_enq[gi]     = accept & target_mask[gi];
      assign out_wdata[gi]   = buf_mem[ptr_reg];
    end
  endgenerate

  // Only full flags of targeted lanes can stall; abort suppresses the
  // enqueue in the same cycle it is raised.
  assign accept   = (state_reg == SEND) && !abort &&
                    ((target_mask & out_full) == '0);
  assign last_pkt = ((sent_cnt_reg + (AW+1)'(1)) == len_reg);

  // ---------------------------------------------------------------------
  // Buffer write port
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (load_en && !busy) begin
      buf_mem[load_addr] <= load_data;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = (cfg_len == '0) ? DONE : SEND;
        end
      end
      SEND: begin
        if (abort) begin
          state_next = IDLE;
        end else if (accept) begin
          if (last_pkt) begin
            state_next = DONE;
          end else if (gap_reg != '0) begin
            state_next = GAP;
          end
        end
      end
      GAP: begin
        // Counter was loaded with gap on acceptance, so the value 1 marks
        // the last idle cycle.
        if (abort) begin
          state_next = IDLE;
        end else if (gap_cnt_reg <= GAP_W'(1)) begin
          state_next = SEND;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      ptr_reg      <= '0;
      sent_cnt_reg <= '0;
      gap_cnt_reg  <= '0;
      len_reg      <= '0;
      gap_reg      <= '0;
      bcast_reg    <= 1'b0;
      ch_reg       <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (start) begin
            len_reg      <= cfg_len;
            gap_reg      <= cfg_gap;
            bcast_reg    <= cfg_bcast;
            ch_reg       <= cfg_ch;
            ptr_reg      <= '0;
            sent_cnt_reg <= '0;
          end
        end
        SEND: begin
          if (accept) begin
            // ptr wraps to 0 only after the final entry of a full-depth
            // stream, when it is no longer read.
            ptr_reg      <= ptr_reg + AW'(1);
            sent_cnt_reg <= sent_cnt_reg + (AW+1)'(1);
            gap_cnt_reg  <= gap_reg;
          end
        end
        GAP: begin
          if (!abort) begin
            gap_cnt_reg <= gap_cnt_reg - GAP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Status outputs
  // ---------------------------------------------------------------------
  assign busy     = (state_reg == SEND) || (state_reg == GAP);
  assign done     = (state_reg == DONE);
  assign sent_cnt = sent_cnt_reg;

endmodule

// File: tb/tb_pkt_stream_src.sv
// Randomized scoreboard bench for pkt_stream_src.
// Stimulus pushes the packets each lane should receive (taken from a
// bench-side copy of the buffer) and the expected final count; a monitor
// on the falling edge pops and compares whenever the DUT enqueues or
// pulses done.
module tb_pkt_stream_src;
  import pe_types::packet_t;

  localparam int NUM_CH = 4;
  localparam int DEPTH  = 16;
  localparam int GAP_W  = 4;
  localparam int AW     = 4;

  logic                  clk;
  logic                  rst_n;
  logic                  load_en;
  logic [AW-1:0]         load_addr;
  packet_t               load_data;
  logic                  start;
  logic [AW:0]           cfg_len;
  logic [GAP_W-1:0]      cfg_gap;
  logic                  cfg_bcast;
  logic [1:0]            cfg_ch;
  logic                  abort;
  logic [NUM_CH-1:0]     out_full;
  logic [NUM_CH-1:0]     out_enq;
  packet_t [NUM_CH-1:0]  out_wdata;
  logic                  busy;
  logic                  done;
  logic [AW:0]           sent_cnt;

  pkt_stream_src #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .GAP_W(GAP_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .start(start), .cfg_len(cfg_len), .cfg_gap(cfg_gap),
    .cfg_bcast(cfg_bcast), .cfg_ch(cfg_ch), .abort(abort),
    .out_full(out_full), .out_enq(out_enq), .out_wdata(out_wdata),
    .busy(busy), .done(done), .sent_cnt(sent_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream full flags: forced pattern or random back-pressure.
  logic              noise_en = 1'b0;
  logic [NUM_CH-1:0] noise_val = '0;
  logic [NUM_CH-1:0] forced_full = '0;
  always begin
    @(posedge clk);
    #1;
    for (int c = 0; c < NUM_CH; c++) noise_val[c] = ($urandom_range(3) == 0);
  end
  assign out_full = noise_en ? noise_val : forced_full;

  // Reference model and scoreboard
  packet_t           buf_model [DEPTH];
  packet_t           exp_q [NUM_CH][$];
  int                done_q [$];
  logic [NUM_CH-1:0] exp_target = '0;
  int                exp_gap = 0;
  bit                gap_exact = 1'b0;
  int                last_enq_cyc = -1;
  int                last_evt_cyc = 0;
  int                enq_count = 0;
  int                errors = 0;
  int                checks = 0;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor
  always @(negedge clk) begin
    int     idle;
    packet_t e;
    if (rst_n) begin
      if (out_enq != '0) begin
        check("enq_mask", out_enq, exp_target);
        check("enq_while_full", |(out_enq & out_full), 0);
        if (last_enq_cyc >= 0) begin
          idle = cyc - last_enq_cyc - 1;
          if (gap_exact) check("gap_exact", idle, exp_gap);
          else           check("gap_min", idle >= exp_gap, 1);
        end
        for (int c = 0; c < NUM_CH; c++) begin
          if (out_enq[c]) begin
            if (exp_q[c].size() == 0) begin
              check("unexpected_enq", c + 100, 0);
            end else begin
              e = exp_q[c].pop_front();
              check("wdata", out_wdata[c], e);
            end
          end
        end
        $display("enq cyc=%0d mask=%b data=%h", cyc, out_enq, out_wdata[0]);
        last_enq_cyc = cyc;
        last_evt_cyc = cyc;
        enq_count++;
      end
      if (done) begin
        if (done_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          int n;
          n = done_q.pop_front();
          check("done_sent_cnt", sent_cnt, n);
          check("done_timing", cyc, last_evt_cyc + 1);
          for (int c = 0; c < NUM_CH; c++) check("leftover", exp_q[c].size(), 0);
          $display("done cyc=%0d sent_cnt=%0d", cyc, sent_cnt);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_pkt(input int a, input packet_t p);
    load_en = 1'b1; load_addr = AW'(a); load_data = p;
    tick();
    load_en = 1'b0;
    buf_model[a] = p;
  endtask

  task automatic start_stream(input int len, input int gap, input bit bc,
                              input int ch, input bit exact, input bit exp_done);
    exp_target   = bc ? '1 : NUM_CH'(1 << ch);
    exp_gap      = gap;
    gap_exact    = exact;
    last_enq_cyc = -1;
    enq_count    = 0;
    for (int i = 0; i < len; i++)
      for (int c = 0; c < NUM_CH; c++)
        if (exp_target[c]) exp_q[c].push_back(buf_model[i]);
    if (exp_done) done_q.push_back(len);
    cfg_len = (AW+1)'(len); cfg_gap = GAP_W'(gap);
    cfg_bcast = bc; cfg_ch = 2'(ch);
    start = 1'b1;
    last_evt_cyc = cyc;
    tick();
    start = 1'b0;
    $display("start len=%0d gap=%0d bcast=%0d ch=%0d", len, gap, bc, ch);
  endtask

  task automatic wait_done();
    int n = 0;
    while ((done_q.size() != 0 || busy) && n < 3000) begin
      tick();
      n++;
    end
    check("timeout", n < 3000, 1);
    tick();
  endtask

  task automatic flush_model();
    for (int c = 0; c < NUM_CH; c++) exp_q[c].delete();
    done_q.delete();
  endtask

  initial begin
    int k, n;
    rst_n = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; cfg_len = '0; cfg_gap = '0; cfg_bcast = 1'b0; cfg_ch = '0;
    abort = 1'b0;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_enq", out_enq, 0);
    check("rst_sent_cnt", sent_cnt, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < DEPTH; i++) load_pkt(i, packet_t'($urandom));

    // Unicast ch0, len 5, no gap, never full.
    start_stream(5, 0, 1'b0, 0, 1'b1, 1'b1);
    wait_done();
    check("sent_cnt_hold", sent_cnt, 5);

    // Same with gap 3; a start while busy must be ignored.
    start_stream(5, 3, 1'b0, 0, 1'b1, 1'b1);
    tick();
    cfg_len = 1; cfg_bcast = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done();

    // Broadcast len 4 with lane 2 stalled for 10 cycles mid-stream.
    start_stream(4, 1, 1'b1, 0, 1'b0, 1'b1);
    tick();
    forced_full = 4'b0100;
    k = enq_count;
    repeat (10) tick();
    check("stall_no_enq", enq_count, k);
    forced_full = '0;
    wait_done();

    // Unicast ch1 with lane 3 permanently full: never stalls.
    forced_full = 4'b1000;
    start_stream(6, 1, 1'b0, 1, 1'b1, 1'b1);
    wait_done();
    forced_full = '0;

    // Abort after 2 of 8, then replay from entry 0.
    start_stream(8, 0, 1'b0, 2, 1'b1, 1'b0);
    n = 0;
    while (enq_count < 2 && n < 100) begin tick(); n++; end
    check("abort_wait", n < 100, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sent_cnt", sent_cnt, 2);
    flush_model();
    repeat (3) tick();
    start_stream(3, 0, 1'b0, 2, 1'b1, 1'b1);
    wait_done();

    // Zero-length stream.
    start_stream(0, 0, 1'b0, 0, 1'b1, 1'b1);
    wait_done();
    check("len0_enq", enq_count, 0);

    // Reset mid-stream.
    start_stream(10, 1, 1'b1, 0, 1'b1, 1'b1);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_enq", out_enq, 0);
    check("midrst_done", done, 0);
    check("midrst_sent_cnt", sent_cnt, 0);
    flush_model();
    tick(); tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check("post_rst_busy", busy, 0);

    // Loads while busy are dropped (model left unchanged).
    start_stream(4, 2, 1'b0, 0, 1'b1, 1'b1);
    load_en = 1'b1; load_addr = 0; load_data = ~buf_model[0];
    tick();
    load_addr = 1; load_data = ~buf_model[1];
    tick();
    load_en = 1'b0;
    wait_done();
    start_stream(2, 0, 1'b0, 3, 1'b1, 1'b1);
    wait_done();

    // Full-depth broadcast under random back-pressure.
    noise_en = 1'b1;
    start_stream(DEPTH, $urandom_range(2), 1'b1, 0, 1'b0, 1'b1);
    wait_done();
    check("full_depth_cnt", sent_cnt, DEPTH);

    // Random streams.
    for (int t = 0; t < 8; t++) begin
      int ln, gp, ch;
      bit bc, nz;
      for (int j = 0; j < 3; j++) load_pkt($urandom_range(DEPTH-1), packet_t'($urandom));
      ln = $urandom_range(DEPTH); gp = $urandom_range(3);
      bc = 1'($urandom); ch = $urandom_range(NUM_CH-1); nz = 1'($urandom);
      noise_en = nz;
      start_stream(ln, gp, bc, ch, !nz, 1'b1);
      wait_done();
    end
    noise_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
